// File: rtl/axis_arb_pkg.sv
// Shared types and limits for the AXI4-Stream round-robin arbiter.
//   arb_state_t     : arbiter FSM state encoding
//   NUM_SRC_MIN/MAX : legal range for the number of merged sources
//   MAX_BURST_MAX   : largest per-grant beat cap
//   legal_data_wdth : true for the supported tdata widths
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_SRC_MIN   = 2;
  localparam int unsigned NUM_SRC_MAX   = 16;
  localparam int unsigned MAX_BURST_MAX = 256;

  function automatic bit legal_data_wdth(input int unsigned w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: returns the first asserted request
// scanning upward (with wrap) from the slot after 'last'.
//   req     : per-slot request vector
//   last    : index of the most recently served slot
//   any_req : at least one request is asserted
//   pick    : chosen slot index (0 when no request)
module rr_prio_pick #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick
);

  int unsigned cand;

  // Scan last+1 .. last+NUM_SRC; the first hit wins, so 'last' itself is lowest priority.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(last) + k) % NUM_SRC;
      if (!any_req && req[IDX_W'(cand)]) begin
        any_req = 1'b1;
        pick    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arb.sv
// Packet-aware round-robin merge of NUM_SRC AXI4-Stream sources onto one
// master stream. A grant lasts until the granted source completes a tlast
// beat or MAX_BURST beats have been accepted; one idle cycle separates grants.
//   clk, rst             : clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready : packed per-source slave streams
//   m_axis_tdata/tvalid/tlast/tready : merged master stream (pass-through)
//   grant_id             : index of the granted source
//   grant_vld            : a grant is active (XFER state)
module axis_rr_arb
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned DATA_WDTH = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*DATA_WDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  output logic [DATA_WDTH-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id,
  output logic                           grant_vld
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  // Elaboration-time parameter legality.
  if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
    $fatal(1, "axis_rr_arb: NUM_SRC out of range");
  end
  if (!legal_data_wdth(DATA_WDTH)) begin : g_bad_data_wdth
    $fatal(1, "axis_rr_arb: DATA_WDTH must be 8, 16, 32 or 64");
  end
  if (MAX_BURST < 1 || MAX_BURST > MAX_BURST_MAX) begin : g_bad_max_burst
    $fatal(1, "axis_rr_arb: MAX_BURST out of range");
  end

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DATA_WDTH-1:0] src_data [NUM_SRC];
  logic                 any_req;
  logic [IDX_W-1:0]     pick;
  logic                 hs;
  logic                 at_cap;

  // Unpack the flat slave data bus into per-source words.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = s_axis_tdata[i*DATA_WDTH +: DATA_WDTH];
    end
  end

  rr_prio_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req     (s_axis_tvalid),
    .last    (last_grant_q),
    .any_req (any_req),
    .pick    (pick)
  );

  assign at_cap   = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
  assign grant_id = grant_id_q;

  // State register; last_grant resets to the top slot so source 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next-state and pass-through mux driven from the registered grant.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    grant_vld     = 1'b0;
    hs            = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d = pick;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        grant_vld                 = 1'b1;
        m_axis_tdata              = src_data[grant_id_q];
        m_axis_tvalid             = s_axis_tvalid[grant_id_q];
        m_axis_tlast              = s_axis_tlast[grant_id_q];
        s_axis_tready[grant_id_q] = m_axis_tready;
        hs                        = s_axis_tvalid[grant_id_q] & m_axis_tready;
        if (hs) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // Release on end of packet or when the beat cap is hit.
          if (s_axis_tlast[grant_id_q] || at_cap) begin
            last_grant_d = grant_id_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
